// File: rtl/vctcxo_tamer_pio_poller.sv
// vctcxo_tamer_pio_poller
// Avalon-MM read master that polls a read-only status PIO at a fixed interval,
// keeps the last sampled field and strobes a change mask when bits flip.
// Gives fabric logic the same status view the Nios has of the VCTCXO tamer PIO.

module vctcxo_tamer_pio_poller #(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned POLL_PERIOD  = 1000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_ADDR    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] pio_value,
    output logic              pio_valid,
    output logic              change_pulse,
    output logic [DATA_W-1:0] change_mask,
    output logic              busy
);

    localparam int unsigned TIMER_W = $clog2(POLL_PERIOD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_UPDATE
    } state_t;

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [2:0]          lat_q, lat_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [DATA_W-1:0]   value_q, value_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic                valid_q, valid_d;
    logic                pulse_q, pulse_d;

    // The very first poll after reset skips the interval so consumers see a
    // valid status as early as possible.
    logic poll_due;
    logic data_ready;

    assign poll_due   = enable && (!valid_q || (timer_q == TIMER_W'(POLL_PERIOD - 1)));
    assign data_ready = (lat_q == 3'(READ_LATENCY - 1));

    // Only the low DATA_W bits of the PIO word carry status.
    generate
        if (DATA_W < 32) begin : g_unused_hi
            logic unused_readdata_hi;
            assign unused_readdata_hi = ^avm_readdata[31:DATA_W];
        end
    endgenerate

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one accepted read per poll, then fixed-latency data wait.
    // NOTE: the default assignment before the case keeps this purely
    // combinational; a missing branch would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (poll_due)         state_d = S_REQ;
            S_REQ:       if (!avm_waitrequest) state_d = S_WAIT_DATA;
            S_WAIT_DATA: if (data_ready)       state_d = S_WAIT_DATA == state_q ? S_UPDATE : state_q;
            S_UPDATE:                          state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // Bus-side outputs decoded from the current state.
    always_comb begin
        avm_address = 2'(POLL_ADDR);
        avm_read    = (state_q == S_REQ);
        busy        = (state_q == S_REQ) || (state_q == S_WAIT_DATA);
    end

    // Datapath next values: idle timer, latency counter, sample and change detect.
    always_comb begin
        timer_d  = timer_q;
        lat_d    = lat_q;
        sample_d = sample_q;
        value_d  = value_q;
        valid_d  = valid_q;
        pulse_d  = 1'b0;
        mask_d   = '0;
        case (state_q)
            S_IDLE: begin
                // Timer holds its count while polling is paused.
                if (enable) begin
                    timer_d = poll_due ? '0 : timer_q + TIMER_W'(1);
                end
            end
            S_REQ: begin
                lat_d = '0;
            end
            S_WAIT_DATA: begin
                lat_d = lat_q + 3'd1;
                // readdata is looked at only on its valid cycle, so an idle bus
                // driving X never reaches the holding register.
                if (data_ready) begin
                    sample_d = avm_readdata[DATA_W-1:0];
                end
            end
            S_UPDATE: begin
                timer_d = '0;
                if (!valid_q) begin
                    value_d = sample_q;
                    valid_d = 1'b1;
                end else if (sample_q != value_q) begin
                    value_d = sample_q;
                    mask_d  = sample_q ^ value_q;
                    pulse_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    // NOTE: reset is synchronous and clears every register, including the sample
    // holder, so a transaction cut by reset leaves no trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q  <= '0;
            lat_q    <= '0;
            sample_q <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
            mask_q   <= '0;
        end else begin
            timer_q  <= timer_d;
            lat_q    <= lat_d;
            sample_q <= sample_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            pulse_q  <= pulse_d;
            mask_q   <= mask_d;
        end
    end

    assign pio_value    = value_q;
    assign pio_valid    = valid_q;
    assign change_pulse = pulse_q;
    assign change_mask  = mask_q;

endmodule

// File: tb/tb_vctcxo_tamer_pio_poller.sv
// tb_vctcxo_tamer_pio_poller
// Directed scenarios plus randomized enable/waitrequest/reset traffic, with a
// cycle-level behavioural model of the poller compared on every clock.

module tb_vctcxo_tamer_pio_poller;

    localparam int DW = 4;
    localparam int P  = 10;
    localparam int RL = 1;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          enable = 1'b0;
    logic          wr     = 1'b0;
    logic [1:0]    avm_address;
    logic          avm_read;
    logic [31:0]   rd;
    logic [DW-1:0] pio_value;
    logic          pio_valid;
    logic          change_pulse;
    logic [DW-1:0] change_mask;
    logic          busy;

    always #5 clk = ~clk;

    vctcxo_tamer_pio_poller #(
        .DATA_W      (DW),
        .POLL_PERIOD (P),
        .READ_LATENCY(RL),
        .POLL_ADDR   (0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_waitrequest(wr),
        .avm_readdata   (rd),
        .pio_value      (pio_value),
        .pio_valid      (pio_valid),
        .change_pulse   (change_pulse),
        .change_mask    (change_mask),
        .busy           (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Slave: registered readdata valid RL cycles after acceptance; the low
    // nibble carries the complement on every other cycle so any mistimed
    // sample shows up as a wrong value.
    logic [DW-1:0] slave_val = 4'h5;
    logic [7:0]    acc_sr    = '0;
    logic [31:0]   garbage   = 32'hDEAD_BEEF;
    always @(posedge clk) begin
        acc_sr  <= {acc_sr[6:0], (avm_read === 1'b1) && !wr};
        garbage <= $urandom;
    end
    assign rd = acc_sr[RL-1] ? {garbage[31:4], slave_val} : {garbage[31:4], ~slave_val};

    // Behavioural model: phases tracked with counters, updated at each edge.
    int            cyc         = 0;
    bit            m_read      = 1'b0;
    bit            m_valid     = 1'b0;
    bit            m_pulse     = 1'b0;
    bit            m_upd       = 1'b0;
    logic [DW-1:0] m_value     = '0;
    logic [DW-1:0] m_mask      = '0;
    logic [DW-1:0] m_sample    = '0;
    int            m_idle      = 0;
    int            m_countdown = 0;

    always @(posedge clk) begin
        cyc++;
        m_pulse = 1'b0;
        m_mask  = '0;
        if (reset) begin
            m_read = 1'b0; m_valid = 1'b0; m_value = '0;
            m_idle = 0; m_countdown = 0; m_upd = 1'b0;
        end else if (m_upd) begin
            m_upd  = 1'b0;
            m_idle = 0;
            if (!m_valid) begin
                m_value = m_sample;
                m_valid = 1'b1;
            end else if (m_sample != m_value) begin
                m_mask  = m_sample ^ m_value;
                m_pulse = 1'b1;
                m_value = m_sample;
            end
        end else if (m_countdown > 0) begin
            m_countdown--;
            if (m_countdown == 0) begin
                m_sample = rd[DW-1:0];
                m_upd    = 1'b1;
            end
        end else if (m_read) begin
            if (!wr) begin
                m_read      = 1'b0;
                m_countdown = RL;
            end
        end else if (enable) begin
            if (!m_valid || m_idle == P - 1) begin
                m_read = 1'b1;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    end

    // Monitor and per-cycle compare against the model.
    bit            prev_read     = 1'b0;
    int            rises         = 0;
    int            last_rise     = 0;
    int            prev_rise     = 0;
    int            high_len      = 0;
    int            last_high_len = 0;
    int            pulses        = 0;
    logic [DW-1:0] last_mask     = '0;

    always @(posedge clk) begin
        #1;
        if (avm_read === 1'b1) begin
            if (!prev_read) begin
                rises++;
                prev_rise = last_rise;
                last_rise = cyc;
                high_len  = 0;
            end
            high_len++;
        end else if (prev_read) begin
            last_high_len = high_len;
        end
        prev_read = (avm_read === 1'b1);
        if (change_pulse === 1'b1) begin
            pulses++;
            last_mask = change_mask;
        end
        if (chk_en) begin
            check("avm_read",     avm_read,     m_read);
            check("avm_address",  avm_address,  2'd0);
            check("busy",         busy,         m_read || (m_countdown > 0));
            check("pio_value",    pio_value,    m_value);
            check("pio_valid",    pio_valid,    m_valid);
            check("change_pulse", change_pulse, m_pulse);
            check("change_mask",  change_mask,  m_mask);
        end
    end

    task automatic wait_rise(input int budget, input string name);
        int r0 = rises;
        int n  = 0;
        while (rises == r0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " request seen"}, rises, r0 + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r5;
        int n;
        int r;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset avm_read",  avm_read,  1'b0);
        check("reset busy",      busy,      1'b0);
        check("reset pio_value", pio_value, 4'h0);
        check("reset pio_valid", pio_valid, 1'b0);

        // First poll goes out immediately and captures 0x5 without a pulse.
        reset  = 1'b0;
        enable = 1'b1;
        wait_rise(10, "t1");
        repeat (6) @(negedge clk);
        check("t1 read high cycles", last_high_len, 1);
        check("t1 pio_value",        pio_value,     4'h5);
        check("t1 pio_valid",        pio_valid,     1'b1);
        check("t1 pulses",           pulses,        0);

        // 0x5 -> 0xC between polls gives one pulse with mask 0x9.
        slave_val = 4'hC;
        wait_rise(20, "t2");
        check("t3 request spacing", last_rise - prev_rise, P + RL + 2);
        repeat (6) @(negedge clk);
        check("t2 pulses",     pulses,    1);
        check("t2 mask",       last_mask, 4'h9);
        check("t2 pio_value",  pio_value, 4'hC);
        wait_rise(20, "t2 repeat");
        check("t3 request spacing again", last_rise - prev_rise, P + RL + 2);
        repeat (6) @(negedge clk);
        check("t2 no pulse on same value", pulses, 1);

        // Waitrequest held for 3 REQ cycles: read held 4, one sample taken.
        wr = 1'b1;
        wait_rise(20, "t4");
        slave_val = 4'h3;
        repeat (3) @(negedge clk);
        wr = 1'b0;
        repeat (8) @(negedge clk);
        check("t4 read high cycles", last_high_len, 4);
        check("t4 pio_value",        pio_value,     4'h3);
        check("t4 pulses",           pulses,        2);
        check("t4 mask",             last_mask,     4'hF);

        // Disable during WAIT_DATA: sample still lands, then polling stops.
        wait_rise(20, "t5");
        r5        = rises;
        slave_val = 4'hA;
        @(negedge clk);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check("t5 no request while disabled", rises,     r5);
        check("t5 pio_value",                 pio_value, 4'hA);
        check("t5 mask",                      last_mask, 4'h9);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check("t5 still idle", rises, r5);
        enable = 1'b1;
        n = 0;
        r = rises;
        while (rises == r && n < 30) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("t5 timer resumes", n, P - 4);

        // Reset during WAIT_DATA while the slave presents 0xF.
        slave_val = 4'hF;
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("t6 pio_value",    pio_value,    4'h0);
        check("t6 pio_valid",    pio_valid,    1'b0);
        check("t6 change_pulse", change_pulse, 1'b0);
        check("t6 busy",         busy,         1'b0);
        check("t6 avm_read",     avm_read,     1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t6 stays invalid", pio_valid, 1'b0);

        // Randomized traffic against the model.
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            wr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) slave_val = 4'($urandom);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
